// File: rtl/approx_mul_pkg.sv
// Shared definitions for the sequential approximate RV32M MUL co-processor:
// FSM encoding, MUL decode constants and the step -> byte-pair schedule.
package approx_mul_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [6:0] MUL_OPCODE = 7'b0110011;
    localparam logic [2:0] MUL_FUNCT3 = 3'b000;
    localparam logic [6:0] MUL_FUNCT7 = 7'b0000001;

    localparam logic [3:0] MUL_STEPS = 4'd10;

    typedef struct packed {
        logic [1:0] i;
        logic [1:0] j;
        logic [4:0] shift;
    } step_sel_t;

    // Only byte pairs with i+j <= 3 land in the low word, so ten steps cover it.
    function automatic step_sel_t step_lookup(input logic [3:0] step);
        step_sel_t sel;
        sel = '0;
        case (step)
            4'd0:    {sel.i, sel.j} = {2'd0, 2'd0};
            4'd1:    {sel.i, sel.j} = {2'd0, 2'd1};
            4'd2:    {sel.i, sel.j} = {2'd1, 2'd0};
            4'd3:    {sel.i, sel.j} = {2'd0, 2'd2};
            4'd4:    {sel.i, sel.j} = {2'd1, 2'd1};
            4'd5:    {sel.i, sel.j} = {2'd2, 2'd0};
            4'd6:    {sel.i, sel.j} = {2'd0, 2'd3};
            4'd7:    {sel.i, sel.j} = {2'd1, 2'd2};
            4'd8:    {sel.i, sel.j} = {2'd2, 2'd1};
            4'd9:    {sel.i, sel.j} = {2'd3, 2'd0};
            default: {sel.i, sel.j} = {2'd0, 2'd0};
        endcase
        sel.shift = {sel.i + sel.j, 3'b000};
        return sel;
    endfunction

endpackage

// File: rtl/x8_approx_mul.sv
// Combinational 8x8 approximate multiplier built from four 4x4 partials.
// N4 drops low bits of the low*low partial, N8 drops low bits of the product.
module x8_approx_mul #(
    parameter int N8 = 0,
    parameter int N4 = 0
) (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    localparam logic [7:0]  LL_MASK = 8'hFF << N4;
    localparam logic [15:0] P_MASK  = 16'hFFFF << N8;

    logic [7:0]  pp_ll;
    logic [7:0]  pp_lh;
    logic [7:0]  pp_hl;
    logic [7:0]  pp_hh;
    logic [15:0] sum;

    assign pp_ll = {4'b0, a_i[3:0]} * {4'b0, b_i[3:0]};
    assign pp_lh = {4'b0, a_i[3:0]} * {4'b0, b_i[7:4]};
    assign pp_hl = {4'b0, a_i[7:4]} * {4'b0, b_i[3:0]};
    assign pp_hh = {4'b0, a_i[7:4]} * {4'b0, b_i[7:4]};

    // Largest possible sum is 0xFE01, so 16 bits never overflow.
    assign sum = {8'b0, pp_ll & LL_MASK}
               + {4'b0, pp_lh, 4'b0}
               + {4'b0, pp_hl, 4'b0}
               + {pp_hh, 8'b0};

    assign p_o = sum & P_MASK;

endmodule

// File: rtl/pcpi_approx_mul_seq.sv
// PicoRV32 PCPI co-processor for RV32M MUL, sequencing one shared approximate
// 8x8 multiplier over ten byte pairs. Optional macro: APPROX_MUL_ZERO_SKIP_EN.
module pcpi_approx_mul_seq
    import approx_mul_pkg::*;
#(
    parameter int N8 = 0,
    parameter int N4 = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    logic [1:0]  state_q, state_d;
    logic        hold_q, hold_d;
    logic        wait_q, wait_d;
    logic [3:0]  step_q, step_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] acc_q, acc_d;

    logic        insn_match;
    logic        start;
    step_sel_t   sel;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic [15:0] p16;
    logic [31:0] addend;
    logic        unused_insn_bits;

    assign insn_match = (pcpi_insn[6:0]   == MUL_OPCODE)
                     && (pcpi_insn[14:12] == MUL_FUNCT3)
                     && (pcpi_insn[31:25] == MUL_FUNCT7);
    assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    assign start = pcpi_valid && insn_match && !hold_q;

`ifdef APPROX_MUL_ZERO_SKIP_EN
    logic zero_ops;
    assign zero_ops = (pcpi_rs1 == 32'd0) || (pcpi_rs2 == 32'd0);
`endif

    assign sel    = step_lookup(step_q);
    assign a_byte = a_q[{sel.i, 3'b000} +: 8];
    assign b_byte = b_q[{sel.j, 3'b000} +: 8];

    x8_approx_mul #(
        .N8 (N8),
        .N4 (N4)
    ) u_mul (
        .a_i (a_byte),
        .b_i (b_byte),
        .p_o (p16)
    );

    assign addend = {16'h0000, p16} << sel.shift;

    always_comb begin
        state_d = state_q;
        hold_d  = 1'b0;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d    = pcpi_rs1;
                    b_d    = pcpi_rs2;
                    acc_d  = 32'd0;
                    step_d = 4'd0;
`ifdef APPROX_MUL_ZERO_SKIP_EN
                    state_d = zero_ops ? ST_DONE : ST_RUN;
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                // The core withdrew the instruction; partial result is dropped.
                if (!pcpi_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d  = acc_q + addend;
                    step_d = step_q + 4'd1;
                    if (step_q == MUL_STEPS - 4'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                hold_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        wait_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b0;
            wait_q  <= 1'b0;
            step_q  <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wait_q  <= wait_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign pcpi_wait  = wait_q;
    assign pcpi_ready = (state_q == ST_DONE);
    assign pcpi_wr    = (state_q == ST_DONE);
    assign pcpi_rd    = acc_q;

endmodule

// File: tb/tb_pcpi_approx_mul_seq.sv
// Self-checking bench for pcpi_approx_mul_seq (exact configuration N8=N4=0),
// checking timing and results against a plain-arithmetic MUL reference.
module tb_pcpi_approx_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] INSN_MUL = 32'h02B50533;
    localparam logic [31:0] INSN_ADD = 32'h00B50533;

    pcpi_approx_mul_seq #(
        .N8 (0),
        .N4 (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        return full[31:0];
    endfunction

    function automatic int refLatency(input logic [31:0] a, input logic [31:0] b);
`ifdef APPROX_MUL_ZERO_SKIP_EN
        if (a == 32'd0 || b == 32'd0) return 1;
`endif
        return 11;
    endfunction

    // Issue one MUL in the current cycle (T) and follow it to completion,
    // keeping valid high through the cycle after ready as the core does.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input string tag);
        int lat;
        lat = refLatency(a, b);
        pcpi_valid = 1'b1;
        pcpi_insn  = INSN_MUL;
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        for (int n = 1; n < lat; n++) begin
            nextCycle();
            checkOutput({tag, ".wait"}, {31'd0, pcpi_wait}, 32'd1);
            checkOutput({tag, ".early_ready"}, {31'd0, pcpi_ready}, 32'd0);
        end
        nextCycle();
        checkOutput({tag, ".ready"}, {31'd0, pcpi_ready}, 32'd1);
        checkOutput({tag, ".wr"}, {31'd0, pcpi_wr}, 32'd1);
        checkOutput({tag, ".wait_done"}, {31'd0, pcpi_wait}, 32'd0);
        checkOutput({tag, ".rd"}, pcpi_rd, refMul(a, b));
        nextCycle();
        checkOutput({tag, ".ready_pulse"}, {31'd0, pcpi_ready}, 32'd0);
        nextCycle();
        checkOutput({tag, ".no_restart"}, {31'd0, pcpi_wait | pcpi_ready}, 32'd0);
        pcpi_valid = 1'b0;
    endtask

    // Run idle cycles and confirm nothing is claimed or completed.
    task automatic idleCycles(input int n, input string tag);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            nextCycle();
            if (pcpi_wait || pcpi_ready || pcpi_wr) seen++;
        end
        checkOutput({tag, ".quiet"}, seen, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        pcpi_valid = 1'b0;
        pcpi_insn  = 32'd0;
        pcpi_rs1   = 32'd0;
        pcpi_rs2   = 32'd0;
        repeat (3) nextCycle();
        checkOutput("reset.wr", {31'd0, pcpi_wr}, 32'd0);
        checkOutput("reset.ready", {31'd0, pcpi_ready}, 32'd0);
        checkOutput("reset.wait", {31'd0, pcpi_wait}, 32'd0);
        checkOutput("reset.rd", pcpi_rd, 32'd0);
        reset = 1'b0;
        nextCycle();

        applyStimulus(32'h00000003, 32'h00000005, "mul3x5");
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, "mul_ones");
        applyStimulus(32'h00010000, 32'h00010000, "mul_wrap");

        pcpi_valid = 1'b1;
        pcpi_insn  = INSN_ADD;
        pcpi_rs1   = 32'h12345678;
        pcpi_rs2   = 32'h9ABCDEF0;
        idleCycles(20, "nomatch");
        pcpi_valid = 1'b0;
        nextCycle();

        pcpi_valid = 1'b1;
        pcpi_insn  = INSN_MUL;
        pcpi_rs1   = 32'h00001234;
        pcpi_rs2   = 32'h00005678;
        repeat (4) nextCycle();
        checkOutput("abort.wait_t4", {31'd0, pcpi_wait}, 32'd1);
        pcpi_valid = 1'b0;
        nextCycle();
        checkOutput("abort.wait_t5", {31'd0, pcpi_wait}, 32'd0);
        idleCycles(15, "abort");
        applyStimulus(32'd7, 32'd6, "mul7x6");

        pcpi_valid = 1'b1;
        pcpi_insn  = INSN_MUL;
        pcpi_rs1   = 32'hDEADBEEF;
        pcpi_rs2   = 32'h00C0FFEE;
        repeat (5) nextCycle();
        reset      = 1'b1;
        pcpi_valid = 1'b0;
        nextCycle();
        checkOutput("midreset.wr", {31'd0, pcpi_wr}, 32'd0);
        checkOutput("midreset.ready", {31'd0, pcpi_ready}, 32'd0);
        checkOutput("midreset.wait", {31'd0, pcpi_wait}, 32'd0);
        checkOutput("midreset.rd", pcpi_rd, 32'd0);
        reset = 1'b0;
        idleCycles(15, "midreset");

        applyStimulus(32'h00000000, 32'h00001234, "zero_rs1");
        applyStimulus(32'hCAFEF00D, 32'h00000000, "zero_rs2");

        // Back-to-back random MULs, each starting at the earliest allowed cycle.
        for (int r = 0; r < 20; r++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (r % 5 == 0) ra = ra & 32'h000000FF;
            if (r % 7 == 3) rb = rb & 32'hFF00FF00;
            applyStimulus(ra, rb, "random");
        end

        idleCycles(5, "tail");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
